collision_controller: RTL

COLLISION_CONTROLLER -- requirements
Module: collision_controller

---
 rtl/collision_pkg.sv | 35 +++
 rtl/collision_msg_accum.sv | 53 +++++
 rtl/collision_controller.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/collision_pkg.sv
// Shared opcodes, FSM states, status bit positions and searcher base helper
// for the collision controller.
package collision_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [2:0] OP_LOAD   = 3'd0;
  localparam logic [2:0] OP_GO     = 3'd1;
  localparam logic [2:0] OP_COLL   = 3'd2;
  localparam logic [2:0] OP_STATUS = 3'd3;
  localparam logic [2:0] OP_DIGEST = 3'd4;
  localparam logic [2:0] OP_ABORT  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READY,
    S_SEARCH,
    S_FOUND,
    S_EXHAUSTED
  } state_e;

  localparam int unsigned ST_FOUND     = 0;
  localparam int unsigned ST_BUSY      = 1;
  localparam int unsigned ST_EXHAUSTED = 2;
  localparam int unsigned ST_MSG_FULL  = 3;

  // Evenly split the 32-bit counter space across the searchers.
  function automatic logic [WORD_W-1:0] base_of(input int unsigned idx, input int unsigned num);
    logic [63:0] stride;
    stride = 64'h1_0000_0000 / 64'(num);
    return WORD_W'(64'(idx) * stride);
  endfunction

endpackage

// File: rtl/collision_msg_accum.sv
// Base-message store: appends two words per load at the word pointer.
module collision_msg_accum
  import collision_pkg::*;
#(
  parameter  int unsigned MSG_WORDS = 16,
  localparam int unsigned PTR_W     = $clog2(MSG_WORDS + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clk_en,
  input  logic                        append,
  input  logic                        clear,
  input  logic [WORD_W-1:0]           word_a,
  input  logic [WORD_W-1:0]           word_b,
  output logic [PTR_W-1:0]            ptr_nxt_c,
  output logic                        full_c,
  output logic [WORD_W*MSG_WORDS-1:0] msg
);

  logic [PTR_W-1:0]            ptr_q, ptr_d;
  logic [PTR_W-1:0]            ptr_plus1;
  logic [WORD_W*MSG_WORDS-1:0] msg_q, msg_d;

  assign ptr_plus1 = ptr_q + PTR_W'(1);
  assign ptr_nxt_c = ptr_q + PTR_W'(2);
  assign full_c    = (ptr_q == PTR_W'(MSG_WORDS));
  assign msg       = msg_q;

  always_comb begin
    ptr_d = ptr_q;
    msg_d = msg_q;
    if (clear) begin
      ptr_d = '0;
    end else if (append && !full_c) begin
      ptr_d = ptr_nxt_c;
      for (int unsigned w = 0; w < MSG_WORDS; w++) begin
        if (PTR_W'(w) == ptr_q)     msg_d[WORD_W*w +: WORD_W] = word_a;
        if (PTR_W'(w) == ptr_plus1) msg_d[WORD_W*w +: WORD_W] = word_b;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      msg_q <= '0;
    end else if (clk_en) begin
      ptr_q <= ptr_d;
      msg_q <= msg_d;
    end
  end

endmodule

// File: rtl/collision_controller.sv
// Nios custom-instruction controller that loads a message and dispatches a
// parallel collision search. Optional digest sum: COLLISION_DIGEST_COUNT_EN.
module collision_controller
  import collision_pkg::*;
#(
  parameter int unsigned NUM_SEARCHERS = 4,
  parameter int unsigned MSG_WORDS     = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clk_en,
  input  logic                            start,
  input  logic [WORD_W-1:0]               dataa,
  input  logic [WORD_W-1:0]               datab,
  input  logic [2:0]                      n,
  output logic                            done,
  output logic [WORD_W-1:0]               result,
  output logic [NUM_SEARCHERS-1:0]        srch_start,
  output logic [WORD_W*NUM_SEARCHERS-1:0] srch_base,
  output logic [WORD_W-1:0]               srch_target,
  output logic [WORD_W*MSG_WORDS-1:0]     srch_msg,
  input  logic [NUM_SEARCHERS-1:0]        srch_done,
  input  logic [NUM_SEARCHERS-1:0]        srch_hit,
  input  logic [WORD_W*NUM_SEARCHERS-1:0] srch_result,
  input  logic [WORD_W*NUM_SEARCHERS-1:0] srch_digests,
  output logic                            srch_abort
);

  localparam int unsigned PTR_W = $clog2(MSG_WORDS + 1);

  state_e                   state_q, state_d;
  logic                     done_q, done_d;
  logic [WORD_W-1:0]        result_q, result_d;
  logic [NUM_SEARCHERS-1:0] srch_start_q, srch_start_d;
  logic                     srch_abort_q, srch_abort_d;
  logic [WORD_W-1:0]        target_q, target_d;
  logic [WORD_W-1:0]        collision_q, collision_d;

  logic                     append, clear;
  logic [PTR_W-1:0]         ptr_nxt_c;
  logic                     full_c;
  logic [NUM_SEARCHERS-1:0] hit_vec;
  logic [WORD_W-1:0]        hit_word;
  logic [WORD_W-1:0]        status_c;
  logic [WORD_W-1:0]        digest_word_c;

  collision_msg_accum #(.MSG_WORDS(MSG_WORDS)) u_accum (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .append    (append),
    .clear     (clear),
    .word_a    (dataa),
    .word_b    (datab),
    .ptr_nxt_c (ptr_nxt_c),
    .full_c    (full_c),
    .msg       (srch_msg)
  );

  for (genvar g = 0; g < NUM_SEARCHERS; g++) begin : g_base
    assign srch_base[WORD_W*g +: WORD_W] = base_of(g, NUM_SEARCHERS);
  end

`ifdef COLLISION_DIGEST_COUNT_EN
  logic [WORD_W-1:0] digest_sum_q, digest_sum_d;

  always_comb begin
    digest_sum_d = '0;
    for (int unsigned i = 0; i < NUM_SEARCHERS; i++) begin
      digest_sum_d = digest_sum_d + srch_digests[WORD_W*i +: WORD_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       digest_sum_q <= '0;
    else if (clk_en) digest_sum_q <= digest_sum_d;
  end

  assign digest_word_c = digest_sum_q;
`else
  logic digests_unused;
  assign digests_unused = ^srch_digests;
  assign digest_word_c  = '0;
`endif

  // Lowest-index hit wins: scan from the top so lower channels overwrite.
  always_comb begin
    hit_vec  = srch_done & srch_hit;
    hit_word = '0;
    for (int i = int'(NUM_SEARCHERS) - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_word = srch_result[WORD_W*i +: WORD_W];
    end
  end

  always_comb begin
    status_c               = '0;
    status_c[ST_FOUND]     = (state_q == S_FOUND);
    status_c[ST_BUSY]      = (state_q == S_SEARCH);
    status_c[ST_EXHAUSTED] = (state_q == S_EXHAUSTED);
    status_c[ST_MSG_FULL]  = full_c;
  end

  always_comb begin
    state_d      = state_q;
    done_d       = start;
    result_d     = result_q;
    srch_start_d = '0;
    srch_abort_d = 1'b0;
    target_d     = target_q;
    collision_d  = collision_q;
    append       = 1'b0;
    clear        = 1'b0;

    if (state_q == S_SEARCH) begin
      if (|hit_vec) begin
        collision_d  = hit_word;
        state_d      = S_FOUND;
        srch_abort_d = 1'b1;
      end else if (&srch_done) begin
        state_d = S_EXHAUSTED;
      end
    end

    // Instruction handling follows the search update so ABORT overrides a hit.
    if (start) begin
      unique case (n)
        OP_LOAD: begin
          if (state_q == S_SEARCH || full_c) begin
            result_d = '1;
          end else begin
            append   = 1'b1;
            result_d = WORD_W'(ptr_nxt_c);
            state_d  = (ptr_nxt_c == PTR_W'(MSG_WORDS)) ? S_READY : S_LOAD;
          end
        end
        OP_GO: begin
          if (state_q == S_READY || state_q == S_FOUND || state_q == S_EXHAUSTED) begin
            target_d     = dataa;
            srch_start_d = '1;
            state_d      = S_SEARCH;
            result_d     = WORD_W'(1);
          end else begin
            result_d = '0;
          end
        end
        OP_COLL:   result_d = collision_q;
        OP_STATUS: result_d = status_c;
        OP_DIGEST: result_d = digest_word_c;
        OP_ABORT: begin
          srch_abort_d = (state_q == S_SEARCH);
          clear        = 1'b1;
          collision_d  = '0;
          state_d      = S_IDLE;
          result_d     = WORD_W'(1);
        end
        default:   result_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      done_q       <= 1'b0;
      result_q     <= '0;
      srch_start_q <= '0;
      srch_abort_q <= 1'b0;
      target_q     <= '0;
      collision_q  <= '0;
    end else if (clk_en) begin
      state_q      <= state_d;
      done_q       <= done_d;
      result_q     <= result_d;
      srch_start_q <= srch_start_d;
      srch_abort_q <= srch_abort_d;
      target_q     <= target_d;
      collision_q  <= collision_d;
    end
  end

  assign done        = done_q;
  assign result      = result_q;
  assign srch_start  = srch_start_q;
  assign srch_abort  = srch_abort_q;
  assign srch_target = target_q;

endmodule
